// File: rtl/ins_sequencer_r32i_if.sv
`default_nettype none
// ============================================================================
// Module   : ins_sequencer_r32i_if
// Purpose  : Handshake, decoder-flag and strobe bundle between the RV32I
//            sequencer (slave side) and the core datapath/memories (master).
// Revision : 1.0 - initial release
// ============================================================================
interface ins_sequencer_r32i_if #(
    parameter int DATA_W = 32
);
    logic              halt;
    logic              imemAck;
    logic              dmemAck;
    logic              RegWriteControl;
    logic              RAMWriteControl;
    logic              RAMRegRead;
    logic              AlwaysBranch;
    logic              TestBranch;
    logic              branchTaken;
    logic              imemReq;
    logic              IRLoad;
    logic              dmemReq;
    logic              dmemWe;
    logic              RegWriteEn;
    logic              PCWriteEn;
    logic              PCSelBranch;
    logic              halted;
    logic              fault;
    logic [DATA_W-1:0] retireCount;

    modport slave (
        input  halt, imemAck, dmemAck, RegWriteControl, RAMWriteControl,
               RAMRegRead, AlwaysBranch, TestBranch, branchTaken,
        output imemReq, IRLoad, dmemReq, dmemWe, RegWriteEn, PCWriteEn,
               PCSelBranch, halted, fault, retireCount
    );

    modport master (
        output halt, imemAck, dmemAck, RegWriteControl, RAMWriteControl,
               RAMRegRead, AlwaysBranch, TestBranch, branchTaken,
        input  imemReq, IRLoad, dmemReq, dmemWe, RegWriteEn, PCWriteEn,
               PCSelBranch, halted, fault, retireCount
    );
endinterface
`default_nettype wire

// File: rtl/ins_sequencer_r32i.sv
`default_nettype none
// ============================================================================
// Module   : ins_sequencer_r32i
// Purpose  : Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control FSM
//            for the RV32I core. Optional macro MEM_TIMEOUT_EN adds a memory
//            ack timeout that parks the core in FAULT.
// Revision : 1.0 - initial release
// ============================================================================
module ins_sequencer_r32i #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  wire logic           clk,
    input  wire logic           nReset,
    ins_sequencer_r32i_if.slave bus_io
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALTED    = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic              started_q;
    logic              take_q, take_d;
    logic [DATA_W-1:0] retire_q, retire_d;
    logic              w_timeout;

    logic w_imemReq, w_IRLoad, w_dmemReq, w_dmemWe;
    logic w_RegWriteEn, w_PCWriteEn, w_PCSelBranch, w_halted, w_fault;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("ins_sequencer_r32i: TIMEOUT out of range 1..65535");
    end

`ifdef MEM_TIMEOUT_EN
    localparam int                 c_WAIT_W  = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT = c_WAIT_W'(TIMEOUT);

    logic [c_WAIT_W-1:0] wait_q, wait_d;

    // Counter holds zero outside a stalled wait, so any state change clears it.
    always_comb begin
        wait_d    = '0;
        w_timeout = 1'b0;
        if ((state_q == S_FETCH && started_q && !bus_io.imemAck) ||
            (state_q == S_MEMORY && !bus_io.dmemAck)) begin
            wait_d    = wait_q + 1'b1;
            w_timeout = (wait_d == c_TIMEOUT);
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q   <= S_FETCH;
            started_q <= 1'b0;
            take_q    <= 1'b0;
            retire_q  <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            take_q    <= take_d;
            retire_q  <= retire_d;
        end
    end

    // started_q keeps imemReq low until the first clock after reset release.
    always_comb begin
        state_d       = state_q;
        take_d        = take_q;
        retire_d      = retire_q;
        w_imemReq     = 1'b0;
        w_IRLoad      = 1'b0;
        w_dmemReq     = 1'b0;
        w_dmemWe      = 1'b0;
        w_RegWriteEn  = 1'b0;
        w_PCWriteEn   = 1'b0;
        w_PCSelBranch = 1'b0;
        w_halted      = 1'b0;
        w_fault       = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (started_q) begin
                    w_imemReq = 1'b1;
                    if (bus_io.imemAck) begin
                        w_IRLoad = 1'b1;
                        state_d  = S_DECODE;
                    end else if (w_timeout) begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                take_d  = bus_io.AlwaysBranch | (bus_io.TestBranch & bus_io.branchTaken);
                state_d = bus_io.RAMRegRead ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                w_dmemReq = 1'b1;
                w_dmemWe  = bus_io.RAMWriteControl;
                if (bus_io.dmemAck) begin
                    state_d = S_WRITEBACK;
                end else if (w_timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_WRITEBACK: begin
                w_PCWriteEn   = 1'b1;
                w_PCSelBranch = take_q;
                w_RegWriteEn  = bus_io.RegWriteControl & ~bus_io.RAMWriteControl;
                retire_d      = retire_q + 1'b1;
                state_d       = bus_io.halt ? S_HALTED : S_FETCH;
            end
            S_HALTED: begin
                w_halted = 1'b1;
                if (!bus_io.halt) begin
                    state_d = S_FETCH;
                end
            end
            S_FAULT: begin
                w_halted = 1'b1;
                w_fault  = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign bus_io.imemReq     = w_imemReq;
    assign bus_io.IRLoad      = w_IRLoad;
    assign bus_io.dmemReq     = w_dmemReq;
    assign bus_io.dmemWe      = w_dmemWe;
    assign bus_io.RegWriteEn  = w_RegWriteEn;
    assign bus_io.PCWriteEn   = w_PCWriteEn;
    assign bus_io.PCSelBranch = w_PCSelBranch;
    assign bus_io.halted      = w_halted;
    assign bus_io.fault       = w_fault;
    assign bus_io.retireCount = retire_q;

endmodule
`default_nettype wire

// File: tb/tb_ins_sequencer_r32i.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_sequencer_r32i
// Purpose  : Directed self-checking bench for ins_sequencer_r32i.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ins_sequencer_r32i;

    // Output vector bit order:
    // imemReq IRLoad dmemReq dmemWe RegWriteEn PCWriteEn PCSelBranch halted fault
    localparam logic [8:0] c_IDLE   = 9'h000;
    localparam logic [8:0] c_FREQ   = 9'h100;
    localparam logic [8:0] c_IRLD   = 9'h180;
    localparam logic [8:0] c_DRD    = 9'h040;
    localparam logic [8:0] c_DWR    = 9'h060;
    localparam logic [8:0] c_WB     = 9'h008;
    localparam logic [8:0] c_WBREG  = 9'h018;
    localparam logic [8:0] c_WBBR   = 9'h00C;
    localparam logic [8:0] c_WBRGBR = 9'h01C;
    localparam logic [8:0] c_HALT   = 9'h002;
    localparam logic [8:0] c_FAULT  = 9'h003;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    ins_sequencer_r32i_if #(.DATA_W(32)) bus ();

    ins_sequencer_r32i #(
        .DATA_W (32),
        .TIMEOUT(4)
    ) u_dut (
        .clk   (clk),
        .nReset(nReset),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    logic [8:0] w_outs;
    assign w_outs = {bus.imemReq, bus.IRLoad, bus.dmemReq, bus.dmemWe, bus.RegWriteEn,
                     bus.PCWriteEn, bus.PCSelBranch, bus.halted, bus.fault};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_dec(input logic rwc, input logic ramw, input logic ramrr,
                           input logic ab, input logic tbr, input logic bt);
        bus.RegWriteControl = rwc;
        bus.RAMWriteControl = ramw;
        bus.RAMRegRead      = ramrr;
        bus.AlwaysBranch    = ab;
        bus.TestBranch      = tbr;
        bus.branchTaken     = bt;
    endtask

    // One clock cycle: drive inputs just after the edge, check mid-cycle.
    task automatic step(input logic iack, input logic dack, input logic hlt,
                        input logic [8:0] exp, input string tag);
        @(posedge clk);
        #1;
        bus.imemAck = iack;
        bus.dmemAck = dack;
        bus.halt    = hlt;
        #1;
        chk(tag, {23'd0, w_outs}, {23'd0, exp});
    endtask

    initial begin
        bus.imemAck = 1'b0;
        bus.dmemAck = 1'b0;
        bus.halt    = 1'b0;
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #2;
        chk("reset_outs", {23'd0, w_outs}, 32'd0);
        chk("reset_retire", bus.retireCount, 32'd0);
        nReset = 1'b1;
        #1;
        chk("release_before_clk", {23'd0, w_outs}, 32'd0);

        // ADDI, zero-wait fetch
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, c_IRLD,  "addi_c1_fetch");
        step(1'b0, 1'b0, 1'b0, c_IDLE,  "addi_c2_decode");
        step(1'b0, 1'b0, 1'b0, c_IDLE,  "addi_c3_exec");
        step(1'b0, 1'b0, 1'b0, c_WBREG, "addi_c4_wb");

        // LW, dmemAck after three wait cycles; stray acks in DECODE ignored
        set_dec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, c_IRLD,  "lw_fetch");
        chk("retire_after_addi", bus.retireCount, 32'd1);
        step(1'b1, 1'b1, 1'b0, c_IDLE,  "lw_decode_stray_ack");
        step(1'b0, 1'b0, 1'b0, c_IDLE,  "lw_exec");
        step(1'b0, 1'b0, 1'b0, c_DRD,   "lw_mem1");
        step(1'b0, 1'b0, 1'b0, c_DRD,   "lw_mem2");
        step(1'b0, 1'b0, 1'b0, c_DRD,   "lw_mem3");
        step(1'b0, 1'b1, 1'b0, c_DRD,   "lw_mem4_ack");
        step(1'b0, 1'b0, 1'b0, c_WBREG, "lw_wb");

        // SW with a one-cycle fetch stall and one data wait cycle
        set_dec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, c_FREQ,  "sw_fetch_stall");
        chk("retire_after_lw", bus.retireCount, 32'd2);
        step(1'b1, 1'b0, 1'b0, c_IRLD,  "sw_fetch");
        step(1'b0, 1'b0, 1'b0, c_IDLE,  "sw_decode");
        step(1'b0, 1'b0, 1'b0, c_IDLE,  "sw_exec");
        step(1'b0, 1'b0, 1'b0, c_DWR,   "sw_mem1");
        step(1'b0, 1'b1, 1'b0, c_DWR,   "sw_mem2_ack");
        step(1'b0, 1'b0, 1'b0, c_WB,    "sw_wb");

        // BEQ taken
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, c_IRLD,  "beq_t_fetch");
        step(1'b0, 1'b0, 1'b0, c_IDLE,  "beq_t_decode");
        step(1'b0, 1'b0, 1'b0, c_IDLE,  "beq_t_exec");
        step(1'b0, 1'b0, 1'b0, c_WBBR,  "beq_t_wb");

        // BEQ not taken
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, c_IRLD,  "beq_nt_fetch");
        step(1'b0, 1'b0, 1'b0, c_IDLE,  "beq_nt_decode");
        step(1'b0, 1'b0, 1'b0, c_IDLE,  "beq_nt_exec");
        step(1'b0, 1'b0, 1'b0, c_WB,    "beq_nt_wb");

        // JAL
        set_dec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, c_IRLD,   "jal_fetch");
        step(1'b0, 1'b0, 1'b0, c_IDLE,   "jal_decode");
        step(1'b0, 1'b0, 1'b0, c_IDLE,   "jal_exec");
        step(1'b0, 1'b0, 1'b0, c_WBRGBR, "jal_wb");

        // ADDI with halt raised in DECODE
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, c_IRLD,  "halt_fetch");
        chk("retire_after_jal", bus.retireCount, 32'd6);
        step(1'b0, 1'b0, 1'b1, c_IDLE,  "halt_decode");
        step(1'b0, 1'b0, 1'b1, c_IDLE,  "halt_exec");
        step(1'b0, 1'b0, 1'b1, c_WBREG, "halt_wb");
        step(1'b0, 1'b0, 1'b1, c_HALT,  "halted1");
        chk("retire_at_halt", bus.retireCount, 32'd7);
        step(1'b1, 1'b1, 1'b1, c_HALT,  "halted2_stray_ack");
        step(1'b0, 1'b0, 1'b0, c_HALT,  "halted_drop");
        step(1'b0, 1'b0, 1'b0, c_FREQ,  "resume_fetch");

        // LW aborted by async reset in MEMORY
        set_dec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, c_IRLD,  "abort_fetch");
        step(1'b0, 1'b0, 1'b0, c_IDLE,  "abort_decode");
        step(1'b0, 1'b0, 1'b0, c_IDLE,  "abort_exec");
        step(1'b0, 1'b0, 1'b0, c_DRD,   "abort_mem1");
        #1;
        nReset = 1'b0;
        #1;
        chk("abort_outs", {23'd0, w_outs}, 32'd0);
        chk("abort_retire", bus.retireCount, 32'd0);
        @(posedge clk);
        #1;
        nReset = 1'b1;
        #1;
        chk("abort_release", {23'd0, w_outs}, 32'd0);
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, c_IRLD,  "post_reset_fetch");
        step(1'b0, 1'b0, 1'b0, c_IDLE,  "post_reset_decode");
        step(1'b0, 1'b0, 1'b0, c_IDLE,  "post_reset_exec");
        step(1'b0, 1'b0, 1'b0, c_WBREG, "post_reset_wb");
        step(1'b0, 1'b0, 1'b0, c_FREQ,  "post_reset_refetch");
        chk("post_reset_retire", bus.retireCount, 32'd1);

`ifdef MEM_TIMEOUT_EN
        // Fetch never acknowledged: FAULT after TIMEOUT=4 wait cycles.
        // The refetch above was wait cycle 1.
        step(1'b0, 1'b0, 1'b0, c_FREQ,  "to_wait2");
        step(1'b0, 1'b0, 1'b0, c_FREQ,  "to_wait3");
        step(1'b0, 1'b0, 1'b0, c_FREQ,  "to_wait4");
        step(1'b0, 1'b0, 1'b0, c_FAULT, "to_fault");
        step(1'b1, 1'b1, 1'b0, c_FAULT, "to_fault_sticky");
        nReset = 1'b0;
        #1;
        chk("to_reset_outs", {23'd0, w_outs}, 32'd0);
        nReset = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
